mbist_ctrl: RTL
===============

MBIST_CTRL -- requirements
Module: mbist_ctrl

Interface
REQ-001 Parameters: DEPTH, 4, number of RAM words; WIDTH, 2, bits per word; AWIDTH, $clog2(DEPTH), address width.
REQ-002 Clocking is fixed: one clock, clk; reset rst_n, asynchronous, active-low.
REQ-003 clk  in  1  single rising-edge clock for all state.
REQ-004 rst_n  in  1  asynchronous active-low reset.
REQ-005 start  in  1  level-sampled; launches a March C- run when sampled high in IDLE.
REQ-006 abort  in  1  synchronous; terminates a run in progress.
REQ-007 busy  out  1  high while the test sequence executes.
REQ-008 done  out  1  one-cycle pulse on normal completion.
REQ-009 fail  out  1  sticky mismatch flag, cleared on next accepted start.
REQ-010 fail_addr  out  AWIDTH  address of first mismatch (diag only, else 0).
REQ-011 fail_elem  out  3  March element index of first mismatch (diag only, else 0).
REQ-012 ram_wr  out  1  RAM write strobe; RAM captures on its rising edge.
REQ-013 ram_addr  out  AWIDTH  RAM address.
REQ-014 ram_din  out  WIDTH  RAM write data.
REQ-015 ram_dout  in  WIDTH  RAM read data, combinational from ram_addr.

Function
REQ-016 The block SHALL run March C-: M0 any(w0); M1 up(r0,w1); M2 up(r1,w0); M3 down(r0,w1); M4 down(r1,w0); M5 any(r0); M0 and M5 run ascending; 0 = all-zeros, 1 = all-ones WIDTH data.
REQ-017 FSM states SHALL be IDLE, READ, WSETUP, WSTROBE, DONE; IDLE->READ (or ->WSETUP for M0) on start.
REQ-018 Read op SHALL take 1 cycle: ram_wr=0, ram_dout compared to expected at the closing edge.
REQ-019 Write op SHALL take 2 cycles: WSETUP drives ram_addr/ram_din with ram_wr=0; WSTROBE holds them with ram_wr=1.
REQ-020 ram_addr and ram_din SHALL be stable throughout each op; ram_wr SHALL never be high outside WSTROBE.
REQ-021 Run length SHALL be exactly 15*DEPTH busy cycles (M0 2N, M1-M4 3N each, M5 N).
REQ-022 busy SHALL rise in the cycle after start is sampled; the cycle after the last op SHALL be DONE with done=1, busy=0; then IDLE.
REQ-023 Address SHALL count 0..DEPTH-1 for up elements and DEPTH-1..0 for down; element advances on terminal address; no wrap beyond terminal.
REQ-024 On any mismatch fail SHALL set at the closing edge and the run SHALL continue to completion.
REQ-025 start while busy or in DONE SHALL be ignored.
REQ-026 abort while busy SHALL return to IDLE next edge with ram_wr=0, busy=0, no done pulse; fail retains its value; abort in IDLE has no effect.
REQ-027 abort and start both high in IDLE: abort SHALL win; no run starts.

Reset
REQ-028 rst_n low SHALL immediately force IDLE and busy, done, fail, ram_wr, fail_addr, fail_elem, ram_addr, ram_din to 0, including mid-run; no RAM write may complete after reset assertion.

Configuration
REQ-029 Macro MBIST_DIAG_EN defined: fail_addr/fail_elem SHALL capture the first mismatch of a run and hold until the next accepted start.
REQ-030 MBIST_DIAG_EN undefined: fail_addr and fail_elem SHALL be constant 0 with no capture registers; ports remain present.

Structure
REQ-031 Package mbist_pkg SHALL hold the FSM state enum, March element enum (M0..M5), op-type enum (READ/WRITE), and the per-element direction/expected/write-data table.
REQ-032 Sub-module mbist_addr_gen SHALL implement the loadable up/down address counter with first/last flags.

Verification (DEPTH=4, WIDTH=2, fault-injectable RAM model)
REQ-033 Fault-free RAM, start pulse -> busy high 60 cycles, done one cycle later, fail=0, final RAM contents all 2'b00.
REQ-034 Bit 1 of addr 2 stuck-at-0 -> fail=1 at first M2 read of addr 2; with MBIST_DIAG_EN fail_addr=2, fail_elem=2; run still completes, done pulses.
REQ-035 abort at busy cycle 20 -> IDLE next edge, ram_wr=0, no done; subsequent start runs full 60 cycles cleanly.
REQ-036 start held high during whole run -> exactly one run; start re-sampled only in IDLE; fail cleared at new start.
REQ-037 rst_n low during a WSTROBE cycle -> all outputs 0 asynchronously, ram_wr drops without completing another edge; IDLE after release.
REQ-038 Build without MBIST_DIAG_EN, repeat REQ-034 stimulus -> fail=1, fail_addr=0, fail_elem=0.

Source files
------------

// File: rtl/mbist_pkg.sv
// Shared types for the March C- memory BIST controller: FSM states, March
// elements, operation types and the per-element sequencing table.
package mbist_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_READ,
        ST_WSETUP,
        ST_WSTROBE,
        ST_DONE
    } state_e;

    typedef enum logic [2:0] {
        M0, M1, M2, M3, M4, M5
    } elem_e;

    typedef enum logic {
        OP_READ,
        OP_WRITE
    } op_e;

    typedef struct packed {
        logic down;
        logic two_ops;
        op_e  first_op;
        op_e  second_op;
        logic exp_one;
        logic wr_one;
    } elem_cfg_t;

    localparam elem_e LAST_ELEM = M5;

    // Columns: down, two_ops, first_op, second_op, read-expect ones, write ones
    function automatic elem_cfg_t elem_cfg(elem_e e);
        case (e)
            M0:      return '{1'b0, 1'b0, OP_WRITE, OP_WRITE, 1'b0, 1'b0};
            M1:      return '{1'b0, 1'b1, OP_READ,  OP_WRITE, 1'b0, 1'b1};
            M2:      return '{1'b0, 1'b1, OP_READ,  OP_WRITE, 1'b1, 1'b0};
            M3:      return '{1'b1, 1'b1, OP_READ,  OP_WRITE, 1'b0, 1'b1};
            M4:      return '{1'b1, 1'b1, OP_READ,  OP_WRITE, 1'b1, 1'b0};
            default: return '{1'b0, 1'b0, OP_READ,  OP_READ,  1'b0, 1'b0};
        endcase
    endfunction

    function automatic state_e op_state(op_e op);
        return (op == OP_WRITE) ? ST_WSETUP : ST_READ;
    endfunction

endpackage

// File: rtl/mbist_ctrl_if.sv
// RAM-side bus of the BIST controller; master drives address/data/strobe,
// slave (the RAM) returns combinational read data.
interface mbist_ctrl_if #(
    parameter int AWIDTH = 2,
    parameter int WIDTH  = 2
);
    logic              ram_wr;
    logic [AWIDTH-1:0] ram_addr;
    logic [WIDTH-1:0]  ram_din;
    logic [WIDTH-1:0]  ram_dout;

    modport master (
        output ram_wr,
        output ram_addr,
        output ram_din,
        input  ram_dout
    );

    modport slave (
        input  ram_wr,
        input  ram_addr,
        input  ram_din,
        output ram_dout
    );
endinterface

// File: rtl/mbist_addr_gen.sv
// Loadable up/down address counter; direction is latched at load so the
// terminal flag always refers to the element currently running.
module mbist_addr_gen #(
    parameter int DEPTH  = 4,
    parameter int AWIDTH = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr,
    input  logic              load,
    input  logic              load_down,
    input  logic              step,
    output logic [AWIDTH-1:0] addr,
    output logic              first,
    output logic              last
);
    localparam logic [AWIDTH-1:0] TOP = AWIDTH'(DEPTH - 1);

    logic down_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr   <= '0;
            down_q <= 1'b0;
        end else if (clr) begin
            addr   <= '0;
            down_q <= 1'b0;
        end else if (load) begin
            addr   <= load_down ? TOP : '0;
            down_q <= load_down;
        end else if (step && !last) begin
            addr <= down_q ? addr - AWIDTH'(1) : addr + AWIDTH'(1);
        end
    end

    assign first = down_q ? (addr == TOP) : (addr == '0);
    assign last  = down_q ? (addr == '0)  : (addr == TOP);

endmodule

// File: rtl/mbist_ctrl.sv
// March C- memory BIST controller (1-cycle reads, 2-cycle writes).
// Define MBIST_DIAG_EN to capture the address/element of the first mismatch.
module mbist_ctrl
    import mbist_pkg::*;
#(
    parameter int DEPTH  = 4,
    parameter int WIDTH  = 2,
    parameter int AWIDTH = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    output logic              busy,
    output logic              done,
    output logic              fail,
    output logic [AWIDTH-1:0] fail_addr,
    output logic [2:0]        fail_elem,
    mbist_ctrl_if.master      ram
);
    state_e            state_q, state_nxt;
    elem_e             elem_q, elem_nxt, elem_inc;
    logic              second_q, second_nxt;
    logic              fail_q, fail_set, fail_clr;
    logic              op_done;
    logic              ag_clr, ag_load, ag_load_down, ag_step;
    logic              ag_first, ag_last;
    logic [AWIDTH-1:0] ag_addr;
    logic [WIDTH-1:0]  exp_data;
    logic              mismatch;

    mbist_addr_gen #(
        .DEPTH  (DEPTH),
        .AWIDTH (AWIDTH)
    ) u_addr_gen (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr       (ag_clr),
        .load      (ag_load),
        .load_down (ag_load_down),
        .step      (ag_step),
        .addr      (ag_addr),
        .first     (ag_first),
        .last      (ag_last)
    );

    assign exp_data = {WIDTH{elem_cfg(elem_q).exp_one}};
    assign mismatch = (ram.ram_dout != exp_data);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_nxt;
        end
    end

    always_comb begin
        state_nxt    = state_q;
        elem_nxt     = elem_q;
        second_nxt   = second_q;
        ag_clr       = 1'b0;
        ag_load      = 1'b0;
        ag_load_down = 1'b0;
        ag_step      = 1'b0;
        fail_set     = 1'b0;
        fail_clr     = 1'b0;
        op_done      = 1'b0;
        elem_inc     = elem_e'(elem_q + 3'd1);

        case (state_q)
            ST_IDLE: begin
                if (start && !abort) begin
                    fail_clr     = 1'b1;
                    elem_nxt     = M0;
                    second_nxt   = 1'b0;
                    ag_load      = 1'b1;
                    ag_load_down = elem_cfg(M0).down;
                    state_nxt    = op_state(elem_cfg(M0).first_op);
                end
            end
            ST_READ: begin
                fail_set = mismatch;
                op_done  = 1'b1;
            end
            ST_WSETUP:  state_nxt = ST_WSTROBE;
            ST_WSTROBE: op_done   = 1'b1;
            ST_DONE: begin
                state_nxt = ST_IDLE;
                ag_clr    = 1'b1;
            end
            default: state_nxt = ST_IDLE;
        endcase

        // Sequence the next op: second op at this address, next address, or next element
        if (op_done) begin
            if (elem_cfg(elem_q).two_ops && !second_q) begin
                second_nxt = 1'b1;
                state_nxt  = op_state(elem_cfg(elem_q).second_op);
            end else begin
                second_nxt = 1'b0;
                if (!ag_last) begin
                    ag_step   = 1'b1;
                    state_nxt = op_state(elem_cfg(elem_q).first_op);
                end else if (elem_q == LAST_ELEM) begin
                    state_nxt = ST_DONE;
                end else begin
                    elem_nxt     = elem_inc;
                    ag_load      = 1'b1;
                    ag_load_down = elem_cfg(elem_inc).down;
                    state_nxt    = op_state(elem_cfg(elem_inc).first_op);
                end
            end
        end

        if (abort && busy) begin
            state_nxt  = ST_IDLE;
            elem_nxt   = M0;
            second_nxt = 1'b0;
            ag_clr     = 1'b1;
            ag_load    = 1'b0;
            ag_step    = 1'b0;
            fail_set   = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            elem_q   <= M0;
            second_q <= 1'b0;
            fail_q   <= 1'b0;
        end else begin
            elem_q   <= elem_nxt;
            second_q <= second_nxt;
            if (fail_clr) begin
                fail_q <= 1'b0;
            end else if (fail_set) begin
                fail_q <= 1'b1;
            end
        end
    end

`ifdef MBIST_DIAG_EN
    logic [AWIDTH-1:0] diag_addr_q;
    logic [2:0]        diag_elem_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            diag_addr_q <= '0;
            diag_elem_q <= '0;
        end else if (fail_clr) begin
            diag_addr_q <= '0;
            diag_elem_q <= '0;
        end else if (fail_set && !fail_q) begin
            diag_addr_q <= ag_addr;
            diag_elem_q <= elem_q;
        end
    end

    assign fail_addr = diag_addr_q;
    assign fail_elem = diag_elem_q;
`else
    assign fail_addr = '0;
    assign fail_elem = '0;
`endif

    assign busy         = (state_q == ST_READ) || (state_q == ST_WSETUP) || (state_q == ST_WSTROBE);
    assign done         = (state_q == ST_DONE);
    assign fail         = fail_q;
    assign ram.ram_wr   = (state_q == ST_WSTROBE);
    assign ram.ram_addr = ag_addr;
    assign ram.ram_din  = busy ? {WIDTH{elem_cfg(elem_q).wr_one}} : '0;

    // Every element load must land on that element's starting address
    a_load_first: assert property (@(posedge clk) disable iff (!rst_n) ag_load |=> ag_first);

endmodule
